// File: rtl/cpc_ram_bank_ctrl_if.sv
// CPC expansion-bus signals seen by the 512K RAM bank controller, plus its SRAM-side outputs.
// Bus handshake: a memory cycle opens when MREQ_B and RD_B/WR_B are sampled low and closes when either is sampled high.
interface cpc_ram_bank_ctrl_if;
  logic [1:0] A;
  logic [7:0] D;
  logic       MREQ_B;
  logic       IOREQ_B;
  logic       RD_B;
  logic       WR_B;
  logic       M1_B;
  logic       RAMRD_B;
  logic [4:0] HIADR;
  logic       RAMCS_B;
  logic       RAMOE_B;
  logic       RAMWE_B;
  logic       RAMDIS;
  logic [5:0] CFG_STATE;
  logic [1:0] cyc_state;

  modport master (
    output A, D, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RAMRD_B,
    input  HIADR, RAMCS_B, RAMOE_B, RAMWE_B, RAMDIS, CFG_STATE, cyc_state
  );

  modport slave (
    input  A, D, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RAMRD_B,
    output HIADR, RAMCS_B, RAMOE_B, RAMWE_B, RAMDIS, CFG_STATE, cyc_state
  );
endinterface

// File: rtl/cpc_ram_bank_ctrl.sv
// 6128-style banking controller for a 512K expansion SRAM: &7Fxx port decode, page mapping, SRAM strobes.
// Optional macro PORT_FULL_DECODE_EN: also require A14=1 for the banking port (full &7Fxx decode).
module cpc_ram_bank_ctrl (
  input  logic CLK,
  input  logic RESET,
  cpc_ram_bank_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_WEND = 2'd3;

  logic [2:0] bank;
  logic [2:0] cfg;
  logic       hit_q;
  logic       io_done;
  logic       port_dec;
  logic       port_hit;
  logic       ext_a;
  logic [1:0] map_pg;
  logic [1:0] state;
  logic [4:0] hiadr_q;
  logic       cs_q;
  logic       oe_q;
  logic       we_q;

`ifdef PORT_FULL_DECODE_EN
  assign port_dec = ~bus.A[1] & bus.A[0];
`else
  assign port_dec = ~bus.A[1];
`endif

  assign port_hit = ~bus.IOREQ_B & ~bus.WR_B & bus.M1_B & port_dec & (bus.D[7:6] == 2'b11);

  // Two consecutive qualified edges filter bus glitches; io_done limits it to one update per I/O cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_q   <= 1'b0;
      io_done <= 1'b0;
      bank    <= 3'd0;
      cfg     <= 3'd0;
    end else begin
      hit_q <= port_hit;
      if (bus.IOREQ_B) begin
        io_done <= 1'b0;
      end else if (port_hit && hit_q && !io_done) begin
        bank    <= bus.D[5:3];
        cfg     <= bus.D[2:0];
        io_done <= 1'b1;
      end
    end
  end

  // Which CPU page is served by the expansion, and which bank page it lands on.
  always_comb begin
    ext_a  = 1'b0;
    map_pg = 2'd3;
    case (cfg)
      3'd0: ext_a = 1'b0;
      3'd1, 3'd3: ext_a = (bus.A == 2'd3);
      3'd2: begin
        ext_a  = 1'b1;
        map_pg = bus.A;
      end
      default: begin
        ext_a  = (bus.A == 2'd1);
        map_pg = cfg[1:0];
      end
    endcase
  end

  assign bus.RAMDIS = ~bus.MREQ_B & ext_a & (~bus.RD_B | ~bus.WR_B);

  // HIADR is captured at cycle start so a mid-cycle bank/cfg change cannot move the SRAM address.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_IDLE;
      hiadr_q <= 5'd0;
      cs_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!bus.MREQ_B && ext_a && !bus.RD_B && !bus.RAMRD_B) begin
            state   <= ST_RD;
            hiadr_q <= {bank, map_pg};
            cs_q    <= 1'b0;
            oe_q    <= 1'b0;
          end else if (!bus.MREQ_B && ext_a && !bus.WR_B) begin
            state   <= ST_WR;
            hiadr_q <= {bank, map_pg};
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
          end
        end
        ST_RD: begin
          if (bus.MREQ_B || bus.RD_B) begin
            state <= ST_IDLE;
            cs_q  <= 1'b1;
            oe_q  <= 1'b1;
          end
        end
        ST_WR: begin
          if (bus.MREQ_B || bus.WR_B) begin
            state <= ST_WEND;
            we_q  <= 1'b1;
          end
        end
        ST_WEND: begin
          state <= ST_IDLE;
          cs_q  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.HIADR     = hiadr_q;
  assign bus.RAMCS_B   = cs_q;
  assign bus.RAMOE_B   = oe_q;
  assign bus.RAMWE_B   = we_q;
  assign bus.CFG_STATE = {bank, cfg};
  assign bus.cyc_state = state;

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// Bench for cpc_ram_bank_ctrl: directed test-plan cases plus random bus traffic against a banking model.
module tb_cpc_ram_bank_ctrl;

  logic CLK = 1'b0;
  logic RESET;

  cpc_ram_bank_ctrl_if bus ();

  cpc_ram_bank_ctrl dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic [6:0] exp_q[$];
  int m_bank = 0;
  int m_cfg  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Banking model: which CPU pages the expansion serves and the bank page they use.
  function automatic logic ext_of(input int cfg, input int page);
    if (cfg == 2) return 1'b1;
    if (cfg == 1 || cfg == 3) return page == 3;
    if (cfg >= 4) return page == 1;
    return 1'b0;
  endfunction

  function automatic int bpage_of(input int cfg, input int page);
    if (cfg == 2) return page;
    if (cfg >= 4) return cfg - 4;
    return 3;
  endfunction

  function automatic logic port_ok(input logic [1:0] a, input logic [7:0] d, input logic m1);
`ifdef PORT_FULL_DECODE_EN
    return m1 && (a == 2'b01) && (d[7:6] == 2'b11);
`else
    return m1 && !a[1] && (d[7:6] == 2'b11);
`endif
  endfunction

  task automatic bus_idle();
    bus.A = 2'd0; bus.D = 8'd0;
    bus.MREQ_B = 1'b1; bus.IOREQ_B = 1'b1; bus.RD_B = 1'b1;
    bus.WR_B = 1'b1; bus.M1_B = 1'b1; bus.RAMRD_B = 1'b1;
  endtask

  // OUT cycle: data d for the first two edges, d2 afterwards; held for 'edges' rising edges.
  task automatic io_write(input logic [1:0] a, input logic [7:0] d, input logic m1,
                          input int edges, input logic [7:0] d2);
    logic prev_ok = 1'b0;
    logic done = 1'b0;
    for (int k = 1; k <= edges; k++) begin
      logic [7:0] v;
      logic ok;
      v  = (k <= 2) ? d : d2;
      ok = port_ok(a, v, m1);
      if (ok && prev_ok && !done) begin
        m_bank = int'(v[5:3]);
        m_cfg  = int'(v[2:0]);
        done   = 1'b1;
      end
      prev_ok = ok;
    end
    @(posedge CLK); #1;
    bus.A = a; bus.D = d; bus.M1_B = m1; bus.IOREQ_B = 1'b0; bus.WR_B = 1'b0;
    for (int i = 0; i < edges; i++) begin
      @(posedge CLK);
      if (i == 1) begin #1; bus.D = d2; end
    end
    #1;
    bus_idle();
    @(posedge CLK);
    @(negedge CLK);
    check("cfg_state", 32'(bus.CFG_STATE), 32'(m_bank * 8 + m_cfg));
  endtask

  // kind: 0 read, 1 write, 2 refresh (MREQ only)
  task automatic mem_cycle(input logic [1:0] page, input int kind, input logic ramrd, input int edges);
    logic ext;
    ext = ext_of(m_cfg, int'(page));
    @(posedge CLK); #1;
    if (ext && (kind == 1 || (kind == 0 && !ramrd)))
      exp_q.push_back({kind == 1, kind == 0, 5'(m_bank * 4 + bpage_of(m_cfg, int'(page)))});
    bus.A = page; bus.D = 8'($urandom); bus.MREQ_B = 1'b0; bus.RAMRD_B = ramrd;
    if (kind == 0) bus.RD_B = 1'b0;
    if (kind == 1) bus.WR_B = 1'b0;
    #1;
    check("ramdis", 32'(bus.RAMDIS), 32'(ext && kind != 2));
    repeat (edges) @(posedge CLK);
    #1;
    bus_idle();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("strobe_missing", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: pops the expected cycle at strobe onset and tracks release ordering.
  initial begin
    logic pcs, pwe, poe, wend_chk;
    logic [4:0] cur_h;
    logic [6:0] e;
    pcs = 1'b1; pwe = 1'b1; poe = 1'b1; wend_chk = 1'b0; cur_h = 5'd0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        pcs = 1'b1; pwe = 1'b1; poe = 1'b1; wend_chk = 1'b0;
        continue;
      end
      if (wend_chk) begin
        check("wend_release", 32'(bus.RAMCS_B), 32'd1);
        wend_chk = 1'b0;
      end
      if (pcs && !bus.RAMCS_B) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got HIADR=%0h want no cycle at %0t", bus.HIADR, $time);
        end else begin
          e = exp_q.pop_front();
          check("onset", 32'({~bus.RAMWE_B, ~bus.RAMOE_B, bus.HIADR}), 32'(e));
          cur_h = e[4:0];
        end
      end else if (!pcs && !bus.RAMCS_B) begin
        check("hiadr_hold", 32'(bus.HIADR), 32'(cur_h));
      end
      if (!pwe && bus.RAMWE_B) begin
        check("wend_cs_hold", 32'(bus.RAMCS_B), 32'd0);
        wend_chk = 1'b1;
      end
      if (!poe && bus.RAMOE_B) check("rd_release", 32'(bus.RAMCS_B), 32'd1);
      pcs = bus.RAMCS_B; pwe = bus.RAMWE_B; poe = bus.RAMOE_B;
    end
  end

  initial begin
    RESET = 1'b1;
    bus_idle();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_cfg", 32'(bus.CFG_STATE), 32'd0);
    check("rst_strobes", 32'({bus.RAMCS_B, bus.RAMOE_B, bus.RAMWE_B}), 32'b111);
    check("rst_hiadr", 32'(bus.HIADR), 32'd0);
    #2 RESET = 1'b0;

    mem_cycle(2'd3, 0, 1'b0, 2);
    io_write(2'b01, 8'hC1, 1'b1, 2, 8'hC1);
    mem_cycle(2'd3, 1, 1'b1, 2);
    io_write(2'b01, 8'hFA, 1'b1, 2, 8'hFA);
    mem_cycle(2'd1, 0, 1'b0, 2);
    io_write(2'b01, 8'hC4, 1'b1, 2, 8'hC4);
    mem_cycle(2'd1, 0, 1'b0, 2);
    mem_cycle(2'd3, 0, 1'b0, 2);
    io_write(2'b01, 8'hC2, 1'b1, 1, 8'hC2);
    io_write(2'b01, 8'hC2, 1'b0, 3, 8'hC2);
    io_write(2'b00, 8'hC2, 1'b1, 2, 8'hC2);
    io_write(2'b01, 8'hC5, 1'b1, 4, 8'hC6);
    mem_cycle(2'd1, 1, 1'b1, 3);

    for (int n = 0; n < 150; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 3) begin
        logic [7:0] d, d2;
        d  = ($urandom_range(0, 3) != 0) ? {2'b11, 6'($urandom)} : 8'($urandom);
        d2 = ($urandom_range(0, 1) != 0) ? {2'b11, 6'($urandom)} : 8'($urandom);
        io_write(2'($urandom), d, ($urandom_range(0, 4) != 0),
                 int'($urandom_range(1, 4)), d2);
      end else begin
        mem_cycle(2'($urandom), (op < 6) ? 0 : (op < 9) ? 1 : 2,
                  ($urandom_range(0, 3) == 0), int'($urandom_range(1, 3)));
      end
    end

    // Reset in the middle of a write must drop strobes without a clock edge.
    io_write(2'b01, 8'hC1, 1'b1, 2, 8'hC1);
    @(posedge CLK); #1;
    exp_q.push_back({1'b1, 1'b0, 5'b00011});
    bus.A = 2'd3; bus.MREQ_B = 1'b0; bus.WR_B = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("mid_wr_we_low", 32'(bus.RAMWE_B), 32'd0);
    #2 RESET = 1'b1;
    m_bank = 0;
    m_cfg  = 0;
    #1;
    check("async_rst_strobes", 32'({bus.RAMCS_B, bus.RAMOE_B, bus.RAMWE_B}), 32'b111);
    check("async_rst_cfg", 32'(bus.CFG_STATE), 32'd0);
    check("async_rst_hiadr", 32'(bus.HIADR), 32'd0);
    @(posedge CLK); #1;
    bus_idle();
    @(negedge CLK);
    #2 RESET = 1'b0;
    exp_q.delete();
    mem_cycle(2'd3, 1, 1'b1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
